// File: rtl/i2s_rx_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// i2s_rx_frame_fifo_if
//   Valid/ready stream carrying one stereo frame (left + right sample).
//   master : producer (drives m_valid, m_left, m_right; samples m_ready)
//   slave  : consumer (drives m_ready; samples m_valid, m_left, m_right)
// ---------------------------------------------------------------------------
interface i2s_rx_frame_fifo_if #(
  parameter int DATA_W = 24
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_left;
  logic [DATA_W-1:0] m_right;

  modport master (output m_valid, output m_left, output m_right, input m_ready);
  modport slave  (input m_valid, input m_left, input m_right, output m_ready);
endinterface

// File: rtl/i2s_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// i2s_rx_frame_fifo
//   Captures each completed I2S stereo frame from the controller's receive
//   path on the lrck falling edge (start of a new left word) and buffers it
//   in a small FWFT FIFO presented as a valid/ready stream. Frames arriving
//   while the FIFO is full are dropped (oldest data kept) and flagged.
//
// Ports
//   clk_audio  : audio clock, also the clock lrck is generated from
//   reset_n    : async active-low reset
//   lrck       : I2S word select (low = left word)
//   rx_l/rx_r  : previous complete frame from the controller
//   m_if       : output frame stream (master modport)
//   ovf_pulse  : one-cycle pulse per dropped frame
//   ovf_flag   : sticky overflow indicator
//   ovf_clr    : clears ovf_flag (a simultaneous drop wins)
//   level      : current occupancy in frames
//   ovf_count  : saturating dropped-frame count (I2S_RX_FIFO_OVF_COUNT_EN)
//
// Build option
//   `define I2S_RX_FIFO_OVF_COUNT_EN adds the ovf_count output.
// ---------------------------------------------------------------------------
module i2s_rx_frame_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_audio,
  input  logic                     reset_n,
  input  logic                     lrck,
  input  logic [DATA_W-1:0]        rx_l,
  input  logic [DATA_W-1:0]        rx_r,
  i2s_rx_frame_fifo_if.master      m_if,
  output logic                     ovf_pulse,
  output logic                     ovf_flag,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   level
`ifdef I2S_RX_FIFO_OVF_COUNT_EN
  ,
  output logic [15:0]              ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic              lrck_q;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_l_q [DEPTH];
  logic [DATA_W-1:0] mem_r_q [DEPTH];
  logic              ovf_pulse_q, ovf_pulse_d;
  logic              ovf_flag_q, ovf_flag_d;

  logic frame_edge, empty, full, pop, push, drop;

  always_comb begin
    frame_edge = lrck_q & ~lrck;
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = m_if.m_valid & m_if.m_ready;
    // A pop in the same cycle frees the slot the push needs. When full the
    // write slot aliases the head slot, but the head is read combinationally
    // this cycle and the write lands next cycle, so there is no hazard.
    push       = frame_edge & (~full | pop);
    drop       = frame_edge & full & ~pop;

    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_pulse_d = drop;
    // Set has priority over clear.
    ovf_flag_d  = drop | (ovf_flag_q & ~ovf_clr);
  end

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      lrck_q      <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_pulse_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
    end else begin
      lrck_q      <= lrck;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_pulse_q <= ovf_pulse_d;
      ovf_flag_q  <= ovf_flag_d;
    end
  end

  // Storage is reset so the head reads 0 out of reset.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_l_q[i] <= '0;
        mem_r_q[i] <= '0;
      end
    end else if (push) begin
      mem_l_q[wr_ptr_q[AW-1:0]] <= rx_l;
      mem_r_q[wr_ptr_q[AW-1:0]] <= rx_r;
    end
  end

  // m_valid is gated by reset so it falls combinationally with reset_n.
  assign m_if.m_valid = reset_n & ~empty;
  assign m_if.m_left  = mem_l_q[rd_ptr_q[AW-1:0]];
  assign m_if.m_right = mem_r_q[rd_ptr_q[AW-1:0]];
  assign ovf_pulse    = ovf_pulse_q;
  assign ovf_flag     = ovf_flag_q;
  // Modulo-2*DEPTH difference yields 0..DEPTH.
  assign level        = wr_ptr_q - rd_ptr_q;

`ifdef I2S_RX_FIFO_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      if (ovf_clr)                  ovf_cnt_d = 16'd1;
      else if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end else if (ovf_clr) begin
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) ovf_cnt_q <= '0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_frame_fifo.sv
module tb_i2s_rx_frame_fifo;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } frame_t;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    int                exp_level;
    logic              exp_valid;
  } vec_t;

  logic              clk_audio = 1'b0;
  logic              reset_n;
  logic              lrck;
  logic [DATA_W-1:0] rx_l, rx_r;
  logic              ovf_pulse, ovf_flag, ovf_clr;
  logic [LW-1:0]     level;
`ifdef I2S_RX_FIFO_OVF_COUNT_EN
  logic [15:0]       ovf_count;
`endif

  i2s_rx_frame_fifo_if #(.DATA_W(DATA_W)) bus ();

  i2s_rx_frame_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_audio (clk_audio),
    .reset_n   (reset_n),
    .lrck      (lrck),
    .rx_l      (rx_l),
    .rx_r      (rx_r),
    .m_if      (bus.master),
    .ovf_pulse (ovf_pulse),
    .ovf_flag  (ovf_flag),
    .ovf_clr   (ovf_clr),
    .level     (level)
`ifdef I2S_RX_FIFO_OVF_COUNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #5 clk_audio = ~clk_audio;

  int     checks   = 0;
  int     failures = 0;
  int     npulse   = 0;
  frame_t sb[$];
  logic   lrck_prev;
  logic   exp_pulse, exp_flag;
  int     exp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    lrck_prev = 1'b1;
    exp_pulse = 1'b0;
    exp_flag  = 1'b0;
    exp_cnt   = 0;
  endtask

  // One clock: update the model from the inputs now applied, advance,
  // then compare registered outputs.
  task automatic cyc();
    bit     edge_m, pop_m, full_m, drop_m;
    frame_t f;
    edge_m = lrck_prev && !lrck;
    full_m = (sb.size() == DEPTH);
    pop_m  = bus.m_ready && (sb.size() != 0);
    if (pop_m) begin
      f = sb.pop_front();
      chk("head_left",  64'(bus.m_left),  64'(f.l));
      chk("head_right", 64'(bus.m_right), 64'(f.r));
    end
    drop_m = 1'b0;
    if (edge_m) begin
      if (!full_m || pop_m) begin
        f.l = rx_l; f.r = rx_r;
        sb.push_back(f);
      end else drop_m = 1'b1;
    end
    exp_pulse = drop_m;
    exp_flag  = drop_m ? 1'b1 : (ovf_clr ? 1'b0 : exp_flag);
    if (drop_m) exp_cnt = ovf_clr ? 1 : ((exp_cnt == 65535) ? 65535 : exp_cnt + 1);
    else if (ovf_clr) exp_cnt = 0;
    lrck_prev = lrck;
    @(posedge clk_audio); #1;
    chk("level",     64'(level),     64'(sb.size()));
    chk("m_valid",   64'(bus.m_valid), 64'(sb.size() != 0));
    chk("ovf_pulse", 64'(ovf_pulse), 64'(exp_pulse));
    chk("ovf_flag",  64'(ovf_flag),  64'(exp_flag));
`ifdef I2S_RX_FIFO_OVF_COUNT_EN
    chk("ovf_count", 64'(ovf_count), 64'(exp_cnt));
`endif
    if (ovf_pulse) npulse++;
  endtask

  // lrck high for one cycle, then low with data: the low cycle is the edge.
  task automatic frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                       input logic rdy, input logic clr);
    lrck = 1'b1; bus.m_ready = 1'b0; ovf_clr = 1'b0;
    cyc();
    lrck = 1'b0; rx_l = l; rx_r = r; bus.m_ready = rdy; ovf_clr = clr;
    cyc();
    bus.m_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic drain();
    bus.m_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (sb.size() == 0) break;
      cyc();
    end
    bus.m_ready = 1'b0;
    chk("drain_empty", 64'(sb.size()), 64'd0);
    cyc();
    chk("valid_after_drain", 64'(bus.m_valid), 64'd0);
  endtask

  vec_t vt[3];

  initial begin
    vt[0] = '{l: 24'h000001, r: 24'hFFFFFF, exp_level: 1, exp_valid: 1'b1};
    vt[1] = '{l: 24'h7FFFFF, r: 24'h800000, exp_level: 2, exp_valid: 1'b1};
    vt[2] = '{l: 24'h123456, r: 24'hABCDEF, exp_level: 3, exp_valid: 1'b1};

    reset_n = 1'b0; lrck = 1'b1; rx_l = '0; rx_r = '0;
    bus.m_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_audio);
    #1;
    chk("rst_valid",   64'(bus.m_valid), 64'd0);
    chk("rst_level",   64'(level),       64'd0);
    chk("rst_left",    64'(bus.m_left),  64'd0);
    chk("rst_right",   64'(bus.m_right), 64'd0);
    chk("rst_pulse",   64'(ovf_pulse),   64'd0);
    chk("rst_flag",    64'(ovf_flag),    64'd0);
    reset_n = 1'b1;
    cyc();
    chk("no_spurious_push", 64'(level), 64'd0);

    // Table: three frames, consumer stalled, then drained in order.
    for (int i = 0; i < 3; i++) begin
      frame(vt[i].l, vt[i].r, 1'b0, 1'b0);
      chk("tbl_level", 64'(level),       64'(vt[i].exp_level));
      chk("tbl_valid", 64'(bus.m_valid), 64'(vt[i].exp_valid));
    end
    chk("tbl_head_l", 64'(bus.m_left),  64'h000001);
    chk("tbl_head_r", 64'(bus.m_right), 64'hFFFFFF);
    drain();

    // Overflow: six edges into a four-deep FIFO.
    npulse = 0;
    for (int i = 1; i <= 6; i++) frame(DATA_W'(i), DATA_W'(24'hA00000 + i), 1'b0, 1'b0);
    cyc();
    chk("ovf_level",  64'(level),    64'(DEPTH));
    chk("ovf_npulse", 64'(npulse),   64'd2);
    chk("ovf_flag_s", 64'(ovf_flag), 64'd1);
`ifdef I2S_RX_FIFO_OVF_COUNT_EN
    chk("ovf_count2", 64'(ovf_count), 64'd2);
`endif
    chk("ovf_head", 64'(bus.m_left), 64'd1);
    drain();

    // Clear flag, fill to full, push and pop in the same cycle.
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("flag_cleared", 64'(ovf_flag), 64'd0);
    npulse = 0;
    for (int i = 1; i <= 4; i++) frame(DATA_W'(24'h100 + i), DATA_W'(24'h200 + i), 1'b0, 1'b0);
    frame(24'h100005, 24'h200005, 1'b1, 1'b0);
    chk("pp_npulse", 64'(npulse),    64'd0);
    chk("pp_level",  64'(level),     64'(DEPTH));
    chk("pp_head",   64'(bus.m_left), 64'h102);
    chk("pp_flag",   64'(ovf_flag),  64'd0);

    // ovf_clr coincident with a drop: set wins; later clear works.
    frame(24'h0BAD01, 24'h0BAD02, 1'b0, 1'b1);
    chk("setwins_flag", 64'(ovf_flag), 64'd1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("clr_flag", 64'(ovf_flag), 64'd0);
    drain();

    // Reset mid-stream with lrck toggling.
    for (int i = 1; i <= 3; i++) frame(DATA_W'(24'h300 + i), DATA_W'(24'h400 + i), 1'b0, 1'b0);
    chk("prerst_level", 64'(level), 64'd3);
    lrck = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.m_valid), 64'd0);
    chk("midrst_level", 64'(level),       64'd0);
    for (int i = 0; i < 4; i++) begin
      lrck = ~lrck;
      @(posedge clk_audio); #1;
      chk("inrst_level", 64'(level), 64'd0);
    end
    lrck = 1'b1;
    reset_n = 1'b1;
    model_reset();
    repeat (3) cyc();
    chk("postrst_level", 64'(level), 64'd0);
    frame(24'h00ABCD, 24'h00DCBA, 1'b0, 1'b0);
    chk("postrst_push", 64'(level), 64'd1);
    drain();

`ifdef I2S_RX_FIFO_OVF_COUNT_EN
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) frame(DATA_W'(i), DATA_W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) frame(24'h5A5A5A, 24'hA5A5A5, 1'b0, 1'b0);
    chk("cnt_sat", 64'(ovf_count), 64'hFFFF);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_rx_frame_fifo.md
# i2s_rx_frame_fifo

- Sits directly downstream of `i2s_controller`'s receive path in the `clk_audio` domain.
- Detects each completed stereo frame from the I2S word-select (`lrck`) and captures the 24-bit left/right pair presented on the controller's `l_data_rx`/`r_data_rx`.
- Buffers captured frames in a small FIFO and presents them to the spatial-processing chain as a valid/ready stream.
- Provides overflow detection when the consumer stalls.

## Interface
Parameters:
- `DATA_W`, 24, sample width per channel.
- `DEPTH`, 4, FIFO depth in stereo frames; power of two, ≥2.

Ports:
- `clk_audio`  in  1  audio clock; same clock that generates `lrck`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `lrck`  in  1  I2S word-select from `i2s_controller`; low = left word.
- `rx_l`  in  DATA_W  left sample from the controller.
- `rx_r`  in  DATA_W  right sample from the controller.
- `m_valid`  out  1  head frame available.
- `m_ready`  in  1  consumer accepts the head frame.
- `m_left`  out  DATA_W  head-frame left sample.
- `m_right`  out  DATA_W  head-frame right sample.
- `ovf_pulse`  out  1  one-cycle pulse when a frame is dropped.
- `ovf_flag`  out  1  sticky overflow indicator.
- `ovf_clr`  in  1  clears `ovf_flag`.
- `level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- `lrck` is synchronous to `clk_audio` and needs no synchronizer. It is registered once into `lrck_q`.
- Frame edge: `lrck_q==1 && lrck==0` (start of a new left word). At that cycle `rx_l`/`rx_r` hold the previous complete frame and are captured as the push data.
- Push on a frame edge:
  - Not full: the pair is written at `wr_ptr` and `wr_ptr` increments.
  - Full: the new frame is dropped (oldest data kept), `ovf_pulse` is asserted for one cycle and `ovf_flag` is set.
- Pop: when `m_valid && m_ready`, `rd_ptr` increments.
- Pointers have `$clog2(DEPTH)+1` bits and wrap modulo 2·DEPTH.
  - Full when the MSBs differ and the lower bits are equal.
  - Empty when the pointers are equal.
- Simultaneous push and pop while full: the pop frees a slot, so the push is accepted and no overflow occurs. `level` is unchanged.
- Simultaneous push and pop while empty: not possible, because `m_valid` is 0.
- `m_left`/`m_right` are first-word-fall-through from the head entry. They are stable while `m_valid && !m_ready`.
- Simultaneous `ovf_clr` and a new overflow: set wins, so `ovf_flag` stays 1.
- No arithmetic is performed on sample data; samples pass bit-exact.

## Timing
- Reset values (async assert, deassert synchronous to `clk_audio` upstream):
  - `lrck_q`=1, so no spurious edge on the first cycle.
  - Pointers 0, `level`=0, `m_valid`=0.
  - `m_left`=`m_right`=0.
  - `ovf_pulse`=0, `ovf_flag`=0.
- Latency: a frame edge detected at cycle N gives `m_valid`=1 and that frame's data at the head at cycle N+1, provided the FIFO was empty.
- `level` updates in the cycle after the push/pop.
- `ovf_pulse` is asserted in cycle N+1 for a drop at edge cycle N.
- A reset asserted mid-stream discards all buffered frames immediately. `m_valid` drops combinationally with reset.
- Throughput: one frame per `lrck` period (minimum 64 `sclk` periods). The consumer may pop one frame per cycle.

## Configuration
- Macro: `I2S_RX_FIFO_OVF_COUNT_EN`.
- Defined:
  - Adds output `ovf_count` [15:0], a saturating count of dropped frames.
  - Reset value 0; increments with each `ovf_pulse`; holds at 16'hFFFF.
  - Cleared by `ovf_clr` in the same cycle `ovf_flag` clears. If a drop and `ovf_clr` coincide, the count becomes 1.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then drive 3 `lrck` falling edges with (`rx_l`,`rx_r`) = (24'h000001, 24'hFFFFFF), (24'h7FFFFF, 24'h800000), (24'h123456, 24'hABCDEF), with `m_ready`=0.
  - Required: `level`=3; `m_valid`=1 from the cycle after the first edge.
  - Then assert `m_ready`=1: the three pairs emerge in order, bit-exact, and `m_valid`=0 afterwards.
- Hold `m_ready`=0 for 6 frame edges with DEPTH=4.
  - Required: `level`=4.
  - `ovf_pulse` fires exactly twice; `ovf_flag`=1.
  - Drain yields frames 1–4 only.
  - With the macro defined: `ovf_count`=2.
- Fill to 4, then drive a frame edge in the same cycle as `m_ready`=1.
  - Required: no `ovf_pulse`; `level` stays 4.
  - Frame 1 pops and the new frame lands at the tail.
- Assert `ovf_clr` in the same cycle as an overflow drop.
  - Required: `ovf_flag` remains 1.
  - On a later `ovf_clr` with no drop, `ovf_flag`=0 the next cycle.
- Assert `reset_n`=0 with 3 frames buffered and `lrck` toggling.
  - Required: `m_valid`=0 and `level`=0 immediately.
  - After release, no push occurs until the next genuine `lrck` 1→0 transition.
- With the macro defined: force 65 540 drops.
  - Required: `ovf_count` saturates at 16'hFFFF.
